// File: rtl/serial_operand_feeder.sv
// Serial operand feeder: accepts a parallel operand pair over valid/ready and
// streams both operands LSB-first, one bit per clock, into a bit-serial adder.
// Each word is followed by FLUSH_CYCLES zero bits. These zeros push the final
// carry out of the adder and clear its carry flop before the next word.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operand pair on op_a/op_b is valid
//   in_ready   feeder can accept a pair this cycle
//   op_a/op_b  parallel operands, sampled only at the accept edge
//   ser_a/ser_b serial operand bits, LSB first
//   bit_valid  high while ser_a/ser_b carry operand bits
//   first_bit  high while bit 0 is driven
//   last_bit   high while bit WIDTH-1 is driven
//   busy       high while a word is shifting or flushing
module serial_operand_feeder #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy
);

    localparam int unsigned CNT_MAX = (WIDTH > FLUSH_CYCLES) ? WIDTH : FLUSH_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] LAST_BIT_CNT   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH_CNT = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CNT_W-1:0] cnt;

    // The shift registers are all-zero outside SHIFT (reset, or fully shifted
    // out by the end of the word), so bit 0 doubles as the registered serial
    // output and reads as zero during flush and idle.
    assign ser_a = sh_a[0];
    assign ser_b = sh_b[0];

    // FSM, datapath and registered framing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            bit_valid <= 1'b0;
            first_bit <= 1'b0;
            last_bit  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= SHIFT;
                        sh_a      <= op_a;
                        sh_b      <= op_b;
                        cnt       <= '0;
                        in_ready  <= 1'b0;
                        bit_valid <= 1'b1;
                        first_bit <= 1'b1;
                        last_bit  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    sh_a      <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b      <= {1'b0, sh_b[WIDTH-1:1]};
                    first_bit <= 1'b0;
                    if (cnt == LAST_BIT_CNT) begin
                        state     <= FLUSH;
                        cnt       <= '0;
                        bit_valid <= 1'b0;
                        last_bit  <= 1'b0;
                    end else begin
                        cnt      <= cnt + CNT_W'(1);
                        // Look ahead one count so last_bit lines up with the final bit
                        last_bit <= ((cnt + CNT_W'(1)) == LAST_BIT_CNT);
                    end
                end
                FLUSH: begin
                    if (cnt == LAST_FLUSH_CNT) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // Unreachable encoding: return to a clean idle
                    state     <= IDLE;
                    sh_a      <= '0;
                    sh_b      <= '0;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    bit_valid <= 1'b0;
                    first_bit <= 1'b0;
                    last_bit  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Testbench for serial_operand_feeder: directed vectors with hand-computed
// serial bits, framing, spacing and sums through a bit-serial adder model.
module tb_serial_operand_feeder;

    localparam int unsigned W = 8;
    localparam int unsigned F = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [7:0] op_a, op_b;
    logic       ser_a, ser_b, bit_valid, first_bit, last_bit, busy;

    logic       in_valid2, in_ready2;
    logic [1:0] op_a2, op_b2;
    logic       ser_a2, ser_b2, bit_valid2, first_bit2, last_bit2, busy2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_operand_feeder #(.WIDTH(W), .FLUSH_CYCLES(F)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .ser_a(ser_a), .ser_b(ser_b),
        .bit_valid(bit_valid), .first_bit(first_bit), .last_bit(last_bit), .busy(busy)
    );

    serial_operand_feeder #(.WIDTH(2), .FLUSH_CYCLES(3)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .op_a(op_a2), .op_b(op_b2), .ser_a(ser_a2), .ser_b(ser_b2),
        .bit_valid(bit_valid2), .first_bit(first_bit2), .last_bit(last_bit2), .busy(busy2)
    );

    // Collector plus bit-serial adder model (carry flop is never reset)
    logic [7:0] col_a, col_b, col_s;
    logic [2:0] idx;
    logic       add_c = 1'b0;
    logic       s_bit;
    logic [7:0] qa[$], qb[$], qs[$];
    logic       qc[$];
    int         acc_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) acc_q.push_back(cyc);
            s_bit = ser_a ^ ser_b ^ add_c;
            if (bit_valid) begin
                if (first_bit) idx = 3'd0;
                col_a[idx] = ser_a;
                col_b[idx] = ser_b;
                col_s[idx] = s_bit;
            end
            add_c = (ser_a & ser_b) | (ser_a & add_c) | (ser_b & add_c);
            if (bit_valid && last_bit) begin
                qa.push_back(col_a);
                qb.push_back(col_b);
                qs.push_back(col_s);
                qc.push_back(add_c);
            end
            if (bit_valid) idx = idx + 3'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                              input logic [7:0] es, input logic ec);
        if (qa.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_a"},     32'(qa.pop_front()), 32'(ea));
            check({tag, "_b"},     32'(qb.pop_front()), 32'(eb));
            check({tag, "_sum"},   32'(qs.pop_front()), 32'(es));
            check({tag, "_carry"}, 32'(qc.pop_front()), 32'(ec));
        end
    endtask

    // Send one pair, scramble operands while busy, wait out the word period
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        op_a = a; op_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; op_a = ~a; op_b = ~b;
        repeat (W + F) tick();
        check("send_ready_back", 32'(in_ready), 32'd1);
    endtask

    logic [7:0] pa[3];
    logic [7:0] pb[3];

    initial begin
        rst = 1'b1; in_valid = 1'b1; op_a = 8'hFF; op_b = 8'hFF;
        in_valid2 = 1'b0; op_a2 = 2'b00; op_b2 = 2'b00;

        // 1: reset with in_valid held high
        repeat (2) tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_bit_valid", 32'(bit_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_ser",       32'({ser_a, ser_b, first_bit, last_bit}), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("rst_no_accept", 32'(busy), 32'd0);

        // 2: A5 + 3C, cycle-exact framing
        op_a = 8'hA5; op_b = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; op_a = 8'h00; op_b = 8'hFF;
        check("t2_first", 32'({first_bit, last_bit, bit_valid, ser_a, ser_b}), 32'b10110);
        repeat (7) tick();
        check("t2_last",  32'({first_bit, last_bit, bit_valid, ser_a, ser_b}), 32'b01110);
        tick();
        check("t2_flush0", 32'({bit_valid, ser_a, ser_b, busy, in_ready}), 32'b00010);
        tick();
        check("t2_flush1", 32'({bit_valid, ser_a, ser_b, busy, in_ready}), 32'b00010);
        tick();
        check("t2_ready", 32'({busy, in_ready}), 32'b01);
        check_word("t2", 8'hA5, 8'h3C, 8'hE1, 1'b0);

        // 3: carry out, then flush must have cleared the carry
        send(8'hFF, 8'h01);
        check_word("t3_ff01", 8'hFF, 8'h01, 8'h00, 1'b1);
        send(8'h00, 8'h00);
        check_word("t3_0000", 8'h00, 8'h00, 8'h00, 1'b0);

        // 4: back-to-back with in_valid held; operands change while busy
        pa[0] = 8'h12; pb[0] = 8'h34;
        pa[1] = 8'h56; pb[1] = 8'h78;
        pa[2] = 8'h9A; pb[2] = 8'hBC;
        acc_q.delete();
        for (int j = 0; j < 3; j++) begin
            int t;
            op_a = pa[j]; op_b = pb[j]; in_valid = 1'b1;
            t = 0;
            while (acc_q.size() <= j && t < 40) begin
                tick();
                t++;
            end
            check("t4_accept_seen", 32'(acc_q.size() > j), 32'd1);
        end
        in_valid = 1'b0; op_a = 8'h00; op_b = 8'h00;
        repeat (W + F) tick();
        if (acc_q.size() == 3) begin
            check("t4_gap01", 32'(acc_q[1] - acc_q[0]), 32'd11);
            check("t4_gap12", 32'(acc_q[2] - acc_q[1]), 32'd11);
        end else begin
            check("t4_accept_count", 32'(acc_q.size()), 32'd3);
        end
        check_word("t4_w0", 8'h12, 8'h34, 8'h46, 1'b0);
        check_word("t4_w1", 8'h56, 8'h78, 8'hCE, 1'b0);
        check_word("t4_w2", 8'h9A, 8'hBC, 8'h56, 1'b1);

        // 5: reset at bit 3, then a clean word
        op_a = 8'h0F; op_b = 8'h00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("t5_mid", 32'({bit_valid, busy}), 32'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_after_rst", 32'({in_ready, bit_valid, busy, ser_a, first_bit}), 32'b10000);
        send(8'h01, 8'h01);
        check_word("t5", 8'h01, 8'h01, 8'h02, 1'b0);

        // 6: WIDTH=2, FLUSH_CYCLES=3 instance
        op_a2 = 2'b01; op_b2 = 2'b10; in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0; op_a2 = 2'b10; op_b2 = 2'b01;
        check("t6_bit0", 32'({first_bit2, last_bit2, bit_valid2, ser_a2, ser_b2}), 32'b10110);
        tick();
        check("t6_bit1", 32'({first_bit2, last_bit2, bit_valid2, ser_a2, ser_b2}), 32'b01101);
        for (int f = 0; f < 3; f++) begin
            tick();
            check("t6_flush", 32'({bit_valid2, ser_a2, ser_b2, busy2, in_ready2}), 32'b00010);
        end
        tick();
        check("t6_ready", 32'({busy2, in_ready2}), 32'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
